tetris_input_ctrl: RTL
======================

Name: tetris_input_ctrl

Overview:
Front-end conditioner that sits directly upstream of the Tetris game FSM. It converts raw, asynchronous push-button levels into clean single-cycle command pulses (en, right, left, rr, rl) and generates the gravity drop tick. A one-deep pending slot holds a move while the FSM is busy, so no press is lost between game states.

Parameters:
SYNC_STAGES, 2, synchronizer flops per button input (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable samples required before the debounced level changes
REPEAT_DELAY, 32, cycles right/left must be held before auto-repeat starts
REPEAT_RATE, 8, cycles between auto-repeat pulses
GRAVITY_BASE, 1024, drop period at level 0, in cycles
GRAVITY_STEP, 64, period reduction per level
GRAVITY_MIN, 64, floor on the drop period
LEVEL_W, 4, width of level input

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
btn_start  in  1  raw start/confirm button
btn_right  in  1  raw move-right button
btn_left  in  1  raw move-left button
btn_rr  in  1  raw rotate-right button
btn_rl  in  1  raw rotate-left button
hold  in  1  high while the FSM cannot accept a move; moves are queued
run  in  1  gravity enable, high in game states
level  in  LEVEL_W  current level, selects the drop period
en  out  1  start pulse, one cycle
right, left, rr, rl  out  1 each  move pulses, one-hot, one cycle
drop_tick  out  1  gravity pulse, one cycle

Behaviour:
- Reset: all outputs 0. Synchronizers, debounced levels, counters and pending slot clear to 0 / NONE.
- Debounce, per button:
  - Counter increments while the synchronized input differs from the debounced level; clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level is a press event.
- Latency: a raw level stable before clock edge 0 produces its output pulse in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. All outputs are registered.
- en:
  - Asserted one cycle per start press.
  - Ignores hold and auto-repeat.
- Auto-repeat (right/left only):
  - A repeat counter starts on press.
  - At REPEAT_DELAY held cycles, a repeat event fires; thereafter one event every REPEAT_RATE cycles while the debounced level stays high.
  - Release clears the counter.
  - rr and rl never repeat.
- Arbitration: events occurring in the same cycle resolve by priority RIGHT > LEFT > ROR > ROL. The winner is taken and the others are dropped.
- Pending slot (move_t):
  - hold=0 and slot NONE: the winning event drives its pulse on the next edge.
  - hold=1: the winning event is stored if the slot is NONE. If the slot is full, new events are dropped (first-wins).
  - When hold falls, the stored move pulses on the next edge and the slot returns to NONE.
  - A new event arriving in that same cycle is dropped.
- Gravity:
  - period = max(GRAVITY_MIN, GRAVITY_BASE - level*GRAVITY_STEP), computed with saturating subtraction (no wrap).
  - The drop counter counts while run=1. At period-1 it pulses drop_tick and reloads 0.
  - run=0 clears the counter; no tick is emitted.
  - A level change takes effect at the next reload.
- Simultaneous drop_tick and a move pulse are both allowed; the FSM gives the move priority.
- Reset mid-press: all state clears. A button still held after reset must re-debounce and then produces a press event.

Decomposition:
- Shared package tetrispkg holds move_t (RIGHT, LEFT, ROR, ROL, DOWN, NONE) and the default timing constants.
- Sub-module btn_debounce (synchronizer, debounce counter, rising-edge detect, parameters SYNC_STAGES/DEBOUNCE_CYCLES), instantiated five times.
- Repeat, arbitration, pending slot and gravity logic live in tetris_input_ctrl.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2. btn_right rises before edge 0 and is held 10 cycles with hold=0 -> right=1 only in the cycle after edge 7; no other pulses.
- btn_rr glitch high for 3 cycles, then low -> no rr pulse, debounced level unchanged.
- hold=1, press rl and then rr -> no pulses while hold=1. hold falls at edge N -> rl=1 in cycle after N; rr never appears.
- btn_right and btn_rr rise in the same cycle, hold=0 -> only right pulses.
- REPEAT_DELAY=32, REPEAT_RATE=8, btn_left held for 60 cycles after debounce -> left pulses at press, +32, +40, +48, +56 (5 total).
- run=1, level=3 -> drop_tick every 832 cycles; level=15 -> every 64 (floor). run=0 mid-count -> no tick; count restarts from 0 when run rises.

Source files
------------

// File: rtl/tetrispkg.sv
// Shared types and default timing constants for the Tetris input front-end.
// move_t  : command codes passed from arbitration to the pending slot.
// DEF_*   : default parameter values used by tetris_input_ctrl and btn_debounce.
package tetrispkg;

  typedef enum logic [2:0] {
    RIGHT,
    LEFT,
    ROR,
    ROL,
    DOWN,
    NONE
  } move_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 32;
  localparam int DEF_REPEAT_RATE     = 8;
  localparam int DEF_GRAVITY_BASE    = 1024;
  localparam int DEF_GRAVITY_STEP    = 64;
  localparam int DEF_GRAVITY_MIN     = 64;
  localparam int DEF_LEVEL_W         = 4;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: synchronizer chain, debounce counter and
// registered rising-edge detector.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   btn_i     : raw asynchronous button level
//   lvl_o     : debounced level
//   press_o   : one-cycle pulse, registered one cycle after lvl_o rises
module btn_debounce
  import tetrispkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic lvl_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   lvl_q;
  logic                   lvl_prev_q;
  logic                   press_q;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign lvl_o   = lvl_q;
  assign press_o = press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      // Any sample that agrees with the current level restarts the count,
      // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
      if (synced == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        lvl_q <= ~lvl_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      lvl_prev_q <= lvl_q;
      press_q    <= lvl_q & ~lvl_prev_q;
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Front-end between the push-buttons and the Tetris game FSM.
// Produces one-cycle command pulses (start, moves) with auto-repeat on
// right/left, fixed-priority arbitration, a one-deep pending slot used while
// the FSM holds off moves, and the level-dependent gravity tick.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   btn_start/right/left/rr/rl : raw button levels
//   hold                     : FSM busy, moves are queued in the pending slot
//   run                      : gravity enable
//   level                    : game level, selects the drop period
//   en                       : start pulse
//   right, left, rr, rl      : one-hot move pulses
//   drop_tick                : gravity pulse
module tetris_input_ctrl
  import tetrispkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int GRAVITY_BASE    = DEF_GRAVITY_BASE,
  parameter int GRAVITY_STEP    = DEF_GRAVITY_STEP,
  parameter int GRAVITY_MIN     = DEF_GRAVITY_MIN,
  parameter int LEVEL_W         = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_right,
  input  logic               btn_left,
  input  logic               btn_rr,
  input  logic               btn_rl,
  input  logic               hold,
  input  logic               run,
  input  logic [LEVEL_W-1:0] level,
  output logic               en,
  output logic               right,
  output logic               left,
  output logic               rr,
  output logic               rl,
  output logic               drop_tick
);

  localparam int BTN_START = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_ROR   = 3;
  localparam int BTN_ROL   = 4;

  // Repeat counter runs 1..REPEAT_DELAY, then cycles through the last
  // REPEAT_RATE values; this needs REPEAT_RATE <= REPEAT_DELAY.
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);

  localparam int GW = $clog2(GRAVITY_BASE + 1);

  // Drop period with saturating subtraction and a floor.
  function automatic logic [GW-1:0] drop_period(input logic [LEVEL_W-1:0] lv);
    int red;
    int per;
    red = int'(lv) * GRAVITY_STEP;
    per = (red >= GRAVITY_BASE) ? 0 : GRAVITY_BASE - red;
    if (per < GRAVITY_MIN) per = GRAVITY_MIN;
    return GW'(per);
  endfunction

  logic [4:0] btn_raw;
  logic [4:0] lvl;
  logic [4:0] press;

  assign btn_raw = {btn_rl, btn_rr, btn_left, btn_right, btn_start};

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[gi]),
      .lvl_o  (lvl[gi]),
      .press_o(press[gi])
    );
  end

  // Only the right/left debounced levels feed the repeat logic.
  logic unused_lvl;
  assign unused_lvl = ^{lvl[BTN_START], lvl[BTN_ROR], lvl[BTN_ROL]};

  logic [RW-1:0] rcnt_q [2];
  logic [1:0]    rep_fire;

  for (genvar ri = 0; ri < 2; ri++) begin : g_rep
    assign rep_fire[ri] = lvl[BTN_RIGHT + ri] && (rcnt_q[ri] == REP_FIRE);
  end

  move_t win;
  move_t pend_q;
  move_t pend_d;
  move_t out_mv;

  always_comb begin
    win = NONE;
    if (press[BTN_RIGHT] || rep_fire[0])     win = RIGHT;
    else if (press[BTN_LEFT] || rep_fire[1]) win = LEFT;
    else if (press[BTN_ROR])                 win = ROR;
    else if (press[BTN_ROL])                 win = ROL;
  end

  // A release of hold always drains the slot first; anything new in that
  // cycle is lost, as is anything arriving while the slot is occupied.
  always_comb begin
    pend_d = pend_q;
    out_mv = NONE;
    if (hold) begin
      if (pend_q == NONE) pend_d = win;
    end else if (pend_q != NONE) begin
      out_mv = pend_q;
      pend_d = NONE;
    end else begin
      out_mv = win;
    end
  end

  // The period is sampled only when a count starts, so a level change
  // applies from the next reload.
  logic [GW-1:0] gcnt_q;
  logic [GW-1:0] per_q;
  logic [GW-1:0] per_sel;

  assign per_sel = (gcnt_q == '0) ? drop_period(level) : per_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) rcnt_q[i] <= '0;
      pend_q    <= NONE;
      gcnt_q    <= '0;
      per_q     <= '0;
      en        <= 1'b0;
      right     <= 1'b0;
      left      <= 1'b0;
      rr        <= 1'b0;
      rl        <= 1'b0;
      drop_tick <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (press[BTN_RIGHT + i])     rcnt_q[i] <= RW'(1);
        else if (!lvl[BTN_RIGHT + i]) rcnt_q[i] <= '0;
        else if (rcnt_q[i] != '0)     rcnt_q[i] <= (rcnt_q[i] == REP_FIRE) ? REP_RELOAD
                                                                          : rcnt_q[i] + 1'b1;
      end

      pend_q <= pend_d;
      en     <= press[BTN_START];
      right  <= (out_mv == RIGHT);
      left   <= (out_mv == LEFT);
      rr     <= (out_mv == ROR);
      rl     <= (out_mv == ROL);

      per_q <= per_sel;
      if (!run) begin
        gcnt_q    <= '0;
        drop_tick <= 1'b0;
      end else if (gcnt_q == per_sel - GW'(1)) begin
        gcnt_q    <= '0;
        drop_tick <= 1'b1;
      end else begin
        gcnt_q    <= gcnt_q + 1'b1;
        drop_tick <= 1'b0;
      end
    end
  end

endmodule
